tag_array_ctrl: RTL and testbench
=================================

# tag_array_ctrl

Front-end controller for the single-port 512-set × 8-way × 19-bit tag SRAM macro. It clears every set after reset, arbitrates between write and read requests for the one shared port (writes win), and turns the macro's next-cycle, non-held read data into a valid/ready response with one-entry backpressure buffering. It sits directly upstream of the macro: its `sram_*` outputs drive the macro's RW0 port, and the macro's read data returns on `sram_rdata`.

## Interface
- `SETS`, 512, number of sets; power of two.
- `WAYS`, 8, ways per set; also the write-mask width.
- `WAY_W`, 19, tag bits per way.
- `ADDR_W`, 9, log2(SETS).
- `clock`  in  1  sole clock; all state changes on its rising edge.
- `reset_n`  in  1  reset; one clock, synchronous and active-low.
- `init_req`  in  1  pulse in RUN: clear the whole array again.
- `init_done`  out  1  high while in RUN.
- `wr_valid` / `wr_ready`  in / out  1 / 1  write handshake.
- `wr_set`  in  ADDR_W  write set index.
- `wr_waymask`  in  WAYS  per-way write enable.
- `wr_data`  in  WAYS*WAY_W  way i occupies bits [i*WAY_W +: WAY_W].
- `rd_valid` / `rd_ready`  in / out  1 / 1  read-request handshake.
- `rd_set`  in  ADDR_W  read set index.
- `resp_valid` / `resp_ready`  out / in  1 / 1  read-response handshake.
- `resp_data`  out  WAYS*WAY_W  all ways of the requested set.
- `sram_en`, `sram_wmode`  out  1 each  macro enable and write mode.
- `sram_addr`  out  ADDR_W  macro address.
- `sram_wmask`  out  WAYS  macro write mask.
- `sram_wdata`  out  WAYS*WAY_W  macro write data.
- `sram_rdata`  in  WAYS*WAY_W  macro read data; valid only in the cycle after a read.

## Operation
- The controller has two states, INIT and RUN.
- **Reset values** (`reset_n` low): state INIT, clear counter 0, `init_done`=0, `resp_valid`=0, response buffer empty, `wr_ready`=`rd_ready`=0. `sram_en` is combinationally gated to 0 while `reset_n` is low.
- **INIT:**
  - Each cycle drives `sram_en`=1, `sram_wmode`=1, `sram_wmask`=all ones, `sram_wdata`=0, `sram_addr`=counter, then increments the counter.
  - After the write to set SETS-1, the state goes to RUN and the counter wraps to 0.
  - `wr_ready`, `rd_ready` and `resp_valid` are all 0 throughout INIT.
- **RUN, write:**
  - `wr_ready`=1.
  - On `wr_valid`, drive the macro with wmode=1, addr=`wr_set`, wmask=`wr_waymask`, wdata=`wr_data`.
  - A zero waymask is still accepted; it leaves the array unchanged.
- **RUN, read:**
  - `rd_ready` = !`wr_valid` && (!`resp_valid` || `resp_ready`). A write in the same cycle stalls the read.
  - A read fire drives the macro with wmode=0, addr=`rd_set`.
- **Response path:**
  - In the cycle after a read fire, `resp_valid`=1 and `resp_data`=`sram_rdata` (bypass).
  - If `resp_ready`=0 in that cycle, `sram_rdata` is captured into the one-entry buffer. `resp_data` then comes from the buffer until the response is accepted.
- **Idle:** when there is no write or read fire, `sram_en`=0.
- **`init_req` in RUN:**
  - The next cycle is INIT with the counter at 0.
  - A pending response is dropped: `resp_valid` goes to 0 and the buffer is emptied.
  - A write or read firing in the same cycle as `init_req` still executes, but the response to that read is dropped.
- **`init_req` in INIT:** ignored.
- **Reset mid-operation:** same as the reset values above; any INIT sweep in progress restarts from set 0.

## Timing
- INIT lasts exactly SETS cycles, starting on the first edge with `reset_n` high. With SETS=512, `init_done` rises 512 cycles after reset release.
- Read latency: fire at cycle t, `resp_valid` at t+1.
- Read throughput: one per cycle while `resp_ready`=1.
- At most one read is outstanding.
- Write latency: a write at cycle t is visible to a read fired at t+1 (response at t+2).
- A write and a read to the same set in the same cycle: the write executes and the read is stalled to t+1, so the read returns the new data.
- `resp_data` is stable from `resp_valid` rising until the response handshake completes.

## Structure
- Package `tag_array_pkg`:
  - constants SETS, WAYS, WAY_W, ADDR_W;
  - the state enum {INIT, RUN};
  - typedefs for way-vector data and set index.
- Sub-module `tag_resp_buf`: one-entry bypass/hold buffer holding the response valid flag and data, with a flush input driven by `init_req`.
- Top level: FSM, clear counter, port arbitration and macro drive.

## Test plan
- **Reset and init:**
  - Release `reset_n`.
  - Expect 512 write cycles with addr 0..511, wmask=0xFF, wdata=0.
  - Expect `init_done`=1 at cycle 512; `wr_ready`/`rd_ready` stay 0 before then.
- **Write then read:**
  - Write set 5, waymask 0x81, way0=0x7FFFF, way7=0x12345.
  - Read set 5 the next cycle.
  - Expect `resp_data` with way0=0x7FFFF, way7=0x12345, other ways 0.
- **Simultaneous write/read:**
  - `wr_valid` and `rd_valid` to set 9 in the same cycle.
  - Expect `rd_ready`=0 that cycle, then the read returns the new data.
- **Backpressure:**
  - Read set 3 with `resp_ready`=0 for 4 cycles, then pulse `sram_rdata` garbage in those cycles.
  - Expect `resp_data` held at the captured value and `rd_ready`=0 until acceptance.
- **Back-to-back reads:**
  - 10 consecutive reads with `resp_ready`=1.
  - Expect 10 responses on consecutive cycles, in order.
- **Re-init:**
  - Assert `init_req` with a response pending.
  - Expect `resp_valid` to drop next cycle and a 512-cycle sweep.
  - A subsequent read of set 5 returns all zeros.

Source files
------------

// File: rtl/tag_array_pkg.sv
// Shared constants and types for the tag SRAM front-end controller.
package tag_array_pkg;

  localparam int SETS   = 512;
  localparam int WAYS   = 8;
  localparam int WAY_W  = 19;
  localparam int ADDR_W = $clog2(SETS);
  localparam int DATA_W = WAYS * WAY_W;

  typedef enum logic {INIT, RUN} state_t;

  typedef logic [DATA_W-1:0] way_vec_t;
  typedef logic [ADDR_W-1:0] set_idx_t;
  typedef logic [WAYS-1:0]   way_mask_t;

endpackage

// File: rtl/tag_resp_buf.sv
// One-entry bypass/hold buffer turning the macro's one-cycle read data into
// a valid/ready response that stays stable under backpressure.
module tag_resp_buf
  import tag_array_pkg::*;
(
  input  logic     clock,
  input  logic     reset_n,
  input  logic     flush,
  input  logic     fire,
  input  logic     resp_ready,
  input  way_vec_t rdata,
  output logic     resp_valid,
  output way_vec_t resp_data
);

  logic     pend;
  logic     buf_valid;
  way_vec_t buf_data;

  // pend marks the cycle in which the macro's read data is on rdata
  assign resp_valid = pend | buf_valid;
  assign resp_data  = buf_valid ? buf_data : rdata;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pend      <= 1'b0;
      buf_valid <= 1'b0;
    end else if (flush) begin
      pend      <= 1'b0;
      buf_valid <= 1'b0;
    end else begin
      pend <= fire;
      if (pend && !resp_ready)
        buf_valid <= 1'b1;
      else if (buf_valid && resp_ready)
        buf_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (pend && !resp_ready)
      buf_data <= rdata;
  end

endmodule

// File: rtl/tag_array_ctrl.sv
// Tag SRAM front-end: post-reset clear sweep, write-priority port
// arbitration and macro drive, with read responses via tag_resp_buf.
module tag_array_ctrl
  import tag_array_pkg::*;
(
  input  logic      clock,
  input  logic      reset_n,
  input  logic      init_req,
  output logic      init_done,
  input  logic      wr_valid,
  output logic      wr_ready,
  input  set_idx_t  wr_set,
  input  way_mask_t wr_waymask,
  input  way_vec_t  wr_data,
  input  logic      rd_valid,
  output logic      rd_ready,
  input  set_idx_t  rd_set,
  output logic      resp_valid,
  input  logic      resp_ready,
  output way_vec_t  resp_data,
  output logic      sram_en,
  output logic      sram_wmode,
  output set_idx_t  sram_addr,
  output way_mask_t sram_wmask,
  output way_vec_t  sram_wdata,
  input  way_vec_t  sram_rdata
);

  state_t   state, state_nxt;
  set_idx_t clr_cnt;
  logic     run;
  logic     wr_fire;
  logic     rd_fire;
  logic     flush;

  assign run       = (state == RUN) && reset_n;
  assign init_done = (state == RUN);
  assign wr_ready  = run;
  assign rd_ready  = run && !wr_valid && (!resp_valid || resp_ready);
  assign wr_fire   = wr_valid && wr_ready;
  assign rd_fire   = rd_valid && rd_ready;
  assign flush     = run && init_req;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state   <= INIT;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= (state == INIT) ? clr_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    state_nxt  = state;
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = '0;
    sram_wmask = '0;
    sram_wdata = '0;
    case (state)
      INIT: begin
        sram_en    = 1'b1;
        sram_wmode = 1'b1;
        sram_addr  = clr_cnt;
        sram_wmask = '1;
        if (clr_cnt == set_idx_t'(SETS - 1))
          state_nxt = RUN;
      end
      RUN: begin
        if (wr_fire) begin
          sram_en    = 1'b1;
          sram_wmode = 1'b1;
          sram_addr  = wr_set;
          sram_wmask = wr_waymask;
          sram_wdata = wr_data;
        end else if (rd_fire) begin
          sram_en   = 1'b1;
          sram_addr = rd_set;
        end
        if (init_req)
          state_nxt = INIT;
      end
      default: state_nxt = INIT;
    endcase
    // The macro must see no access while reset is asserted
    sram_en = sram_en && reset_n;
  end

  tag_resp_buf u_resp_buf (
    .clock      (clock),
    .reset_n    (reset_n),
    .flush      (flush),
    .fire       (rd_fire),
    .resp_ready (resp_ready),
    .rdata      (sram_rdata),
    .resp_valid (resp_valid),
    .resp_data  (resp_data)
  );

endmodule

// File: tb/tb_tag_array_ctrl.sv
// Directed self-checking bench for tag_array_ctrl with a behavioural
// model of the single-port tag macro attached to the sram_* pins.
module tb_tag_array_ctrl;
  import tag_array_pkg::*;

  logic      clock = 1'b0;
  logic      reset_n;
  logic      init_req;
  logic      init_done;
  logic      wr_valid;
  logic      wr_ready;
  set_idx_t  wr_set;
  way_mask_t wr_waymask;
  way_vec_t  wr_data;
  logic      rd_valid;
  logic      rd_ready;
  set_idx_t  rd_set;
  logic      resp_valid;
  logic      resp_ready;
  way_vec_t  resp_data;
  logic      sram_en;
  logic      sram_wmode;
  set_idx_t  sram_addr;
  way_mask_t sram_wmask;
  way_vec_t  sram_wdata;
  way_vec_t  sram_rdata;

  int checks = 0;
  int errors = 0;

  way_vec_t mem [SETS];
  way_vec_t mem_q;
  logic     rd_last = 1'b0;
  way_vec_t garbage;

  always #5 clock = ~clock;

  tag_array_ctrl dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .init_req   (init_req),
    .init_done  (init_done),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_set     (wr_set),
    .wr_waymask (wr_waymask),
    .wr_data    (wr_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_set     (rd_set),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .sram_en    (sram_en),
    .sram_wmode (sram_wmode),
    .sram_addr  (sram_addr),
    .sram_wmask (sram_wmask),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  // Macro read data is only meaningful the cycle after a read
  always @(posedge clock) begin
    rd_last <= sram_en && !sram_wmode;
    if (sram_en && !sram_wmode)
      mem_q <= mem[sram_addr];
    if (sram_en && sram_wmode)
      for (int i = 0; i < WAYS; i++)
        if (sram_wmask[i])
          mem[sram_addr][i*WAY_W +: WAY_W] <= sram_wdata[i*WAY_W +: WAY_W];
  end

  assign sram_rdata = rd_last ? mem_q : garbage;

  task automatic checkOutput(input string tag, input way_vec_t actual, input way_vec_t expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic wv, input set_idx_t ws, input way_mask_t wm,
                               input way_vec_t wd, input logic rv, input set_idx_t rs,
                               input logic rr);
    wr_valid   = wv;
    wr_set     = ws;
    wr_waymask = wm;
    wr_data    = wd;
    rd_valid   = rv;
    rd_set     = rs;
    resp_ready = rr;
    #1;
  endtask

  function automatic way_vec_t pattern(input logic [WAY_W-1:0] base);
    way_vec_t v;
    for (int i = 0; i < WAYS; i++)
      v[i*WAY_W +: WAY_W] = base + WAY_W'(i);
    return v;
  endfunction

  task automatic checkSweep(input int inject_at);
    for (int i = 0; i < SETS; i++) begin
      init_req = (i == inject_at);
      #1;
      checkOutput("init_en",    way_vec_t'(sram_en), way_vec_t'(1));
      checkOutput("init_wmode", way_vec_t'(sram_wmode), way_vec_t'(1));
      checkOutput("init_addr",  way_vec_t'(sram_addr), way_vec_t'(i));
      checkOutput("init_wmask", way_vec_t'(sram_wmask), way_vec_t'(8'hFF));
      checkOutput("init_wdata", sram_wdata, '0);
      checkOutput("init_done0", way_vec_t'(init_done), way_vec_t'(0));
      checkOutput("init_rdy",   way_vec_t'({wr_ready, rd_ready, resp_valid}), way_vec_t'(0));
      tick();
    end
    init_req = 1'b0;
    #1;
    checkOutput("init_done1", way_vec_t'(init_done), way_vec_t'(1));
    checkOutput("wr_ready1",  way_vec_t'(wr_ready), way_vec_t'(1));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    way_vec_t exp_v;
    garbage  = {8{19'h5A5A5}};
    reset_n  = 1'b0;
    init_req = 1'b0;
    applyStimulus(1'b1, 9'd1, 8'hFF, '1, 1'b1, 9'd1, 1'b1);
    tick();
    tick();
    checkOutput("rst_en",        way_vec_t'(sram_en), way_vec_t'(0));
    checkOutput("rst_ready",     way_vec_t'({wr_ready, rd_ready}), way_vec_t'(0));
    checkOutput("rst_resp",      way_vec_t'(resp_valid), way_vec_t'(0));
    checkOutput("rst_init_done", way_vec_t'(init_done), way_vec_t'(0));
    applyStimulus(1'b0, 9'd0, 8'h00, '0, 1'b0, 9'd0, 1'b1);
    reset_n = 1'b1;
    checkSweep(-1);

    // Write set 5 then read it back
    exp_v = '0;
    exp_v[0 +: WAY_W]       = 19'h7FFFF;
    exp_v[7*WAY_W +: WAY_W] = 19'h12345;
    applyStimulus(1'b1, 9'd5, 8'h81, {8{19'h7FFFF}} & ~{{6{19'h7FFFF}}, 19'h0} | exp_v, 1'b0, 9'd0, 1'b1);
    applyStimulus(1'b1, 9'd5, 8'h81, exp_v | {{6{19'h11111}}, 19'h0} , 1'b0, 9'd0, 1'b1);
    checkOutput("wr_en",    way_vec_t'({sram_en, sram_wmode}), way_vec_t'(2'b11));
    checkOutput("wr_addr",  way_vec_t'(sram_addr), way_vec_t'(5));
    checkOutput("wr_wmask", way_vec_t'(sram_wmask), way_vec_t'(8'h81));
    tick();
    applyStimulus(1'b0, 9'd0, 8'h00, '0, 1'b1, 9'd5, 1'b1);
    checkOutput("rd_ready",  way_vec_t'(rd_ready), way_vec_t'(1));
    checkOutput("rd_drive",  way_vec_t'({sram_en, sram_wmode, sram_addr}), way_vec_t'({2'b10, 9'd5}));
    tick();
    applyStimulus(1'b0, 9'd0, 8'h00, '0, 1'b0, 9'd0, 1'b1);
    checkOutput("rd5_valid", way_vec_t'(resp_valid), way_vec_t'(1));
    checkOutput("rd5_data",  resp_data, exp_v);
    tick();
    checkOutput("idle",      way_vec_t'({resp_valid, sram_en}), way_vec_t'(0));

    // Same-cycle write and read to set 9
    applyStimulus(1'b1, 9'd9, 8'hFF, pattern(19'h40000), 1'b1, 9'd9, 1'b1);
    checkOutput("sim_rd_ready", way_vec_t'(rd_ready), way_vec_t'(0));
    checkOutput("sim_wmode",    way_vec_t'(sram_wmode), way_vec_t'(1));
    tick();
    applyStimulus(1'b0, 9'd0, 8'h00, '0, 1'b1, 9'd9, 1'b1);
    checkOutput("sim_rd_ready2", way_vec_t'(rd_ready), way_vec_t'(1));
    tick();
    applyStimulus(1'b0, 9'd0, 8'h00, '0, 1'b0, 9'd0, 1'b1);
    checkOutput("sim_valid", way_vec_t'(resp_valid), way_vec_t'(1));
    checkOutput("sim_data",  resp_data, pattern(19'h40000));
    tick();

    // Zero waymask write leaves set 9 alone; then backpressure on set 3
    applyStimulus(1'b1, 9'd9, 8'h00, '1, 1'b0, 9'd0, 1'b1);
    tick();
    applyStimulus(1'b1, 9'd3, 8'hFF, pattern(19'h2A000), 1'b0, 9'd0, 1'b1);
    tick();
    applyStimulus(1'b0, 9'd0, 8'h00, '0, 1'b1, 9'd3, 1'b0);
    tick();
    for (int c = 0; c < 4; c++) begin
      garbage = pattern(19'h70000 + 19'(c * 16));
      applyStimulus(1'b0, 9'd0, 8'h00, '0, 1'b1, 9'd9, 1'b0);
      checkOutput("bp_valid", way_vec_t'(resp_valid), way_vec_t'(1));
      checkOutput("bp_data",  resp_data, pattern(19'h2A000));
      checkOutput("bp_rd_rdy", way_vec_t'({rd_ready, sram_en}), way_vec_t'(0));
      tick();
    end
    applyStimulus(1'b0, 9'd0, 8'h00, '0, 1'b0, 9'd0, 1'b1);
    checkOutput("bp_acc_data", resp_data, pattern(19'h2A000));
    checkOutput("bp_acc_rdy",  way_vec_t'(rd_ready), way_vec_t'(1));
    tick();
    checkOutput("bp_done", way_vec_t'(resp_valid), way_vec_t'(0));
    applyStimulus(1'b0, 9'd0, 8'h00, '0, 1'b1, 9'd9, 1'b1);
    tick();
    applyStimulus(1'b0, 9'd0, 8'h00, '0, 1'b0, 9'd0, 1'b1);
    checkOutput("zero_mask", resp_data, pattern(19'h40000));
    tick();

    // Ten back-to-back reads of distinct sets
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, set_idx_t'(20 + k), 8'hFF, pattern(WAY_W'((k + 1) << 8)), 1'b0, 9'd0, 1'b1);
      tick();
    end
    for (int k = 0; k <= 10; k++) begin
      applyStimulus(1'b0, 9'd0, 8'h00, '0, k < 10, set_idx_t'(20 + k), 1'b1);
      if (k < 10)
        checkOutput("b2b_rdy", way_vec_t'(rd_ready), way_vec_t'(1));
      checkOutput("b2b_valid", way_vec_t'(resp_valid), way_vec_t'(k > 0));
      if (k > 0)
        checkOutput("b2b_data", resp_data, pattern(WAY_W'(k << 8)));
      tick();
    end

    // Re-init with a response pending, init_req in INIT ignored
    applyStimulus(1'b0, 9'd0, 8'h00, '0, 1'b1, 9'd5, 1'b0);
    tick();
    applyStimulus(1'b0, 9'd0, 8'h00, '0, 1'b0, 9'd0, 1'b0);
    init_req = 1'b1;
    #1;
    checkOutput("ri_pending", way_vec_t'(resp_valid), way_vec_t'(1));
    tick();
    init_req = 1'b0;
    applyStimulus(1'b0, 9'd0, 8'h00, '0, 1'b0, 9'd0, 1'b1);
    checkOutput("ri_dropped", way_vec_t'({resp_valid, init_done}), way_vec_t'(0));
    checkSweep(100);
    applyStimulus(1'b0, 9'd0, 8'h00, '0, 1'b1, 9'd5, 1'b1);
    tick();
    applyStimulus(1'b0, 9'd0, 8'h00, '0, 1'b0, 9'd0, 1'b1);
    checkOutput("ri_valid", way_vec_t'(resp_valid), way_vec_t'(1));
    checkOutput("ri_zero",  resp_data, '0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
